// File: rtl/hwpe_stream_sink_misalign_if.sv
// rtl/hwpe_stream_sink_misalign_if.sv - valid/ready stream bundle used on both sides of the misaligning sink
interface hwpe_stream_sink_misalign_if #(
  parameter int DATA_WIDTH = 32
) ();
  localparam int NB = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [NB-1:0]         strb;
  logic                  last;

  modport master (output valid, data, strb, last, input ready);
  modport slave  (input valid, data, strb, last, output ready);
endinterface

// File: rtl/hwpe_stream_sink_misalign.sv
// rtl/hwpe_stream_sink_misalign.sv - shifts aligned stream lines by a byte offset, adding strobes and a flush beat
module hwpe_stream_sink_misalign #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int LENGTH_WIDTH = 16,
  localparam int NB           = DATA_WIDTH / 8,
  localparam int OW           = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        cfg_valid_i,
  output logic                        cfg_ready_o,
  input  logic [OW-1:0]               cfg_offset_i,
  input  logic [LENGTH_WIDTH-1:0]     cfg_length_i,
  hwpe_stream_sink_misalign_if.slave  push,
  hwpe_stream_sink_misalign_if.master pop,
  output logic                        busy_o,
  output logic                        line_done_o
);

  localparam int SW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [OW-1:0]           r_offset;
  logic [LENGTH_WIDTH-1:0] r_length;
  logic [LENGTH_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0]   r_residue;
  logic                    r_cfg_ready;
  logic                    r_busy;
  logic                    r_line_done;

  logic [SW-1:0]           w_lsh;
  logic [SW-1:0]           w_rsh;
  logic [DATA_WIDTH-1:0]   w_shifted;
  logic [DATA_WIDTH-1:0]   w_carry;
  logic [NB-1:0]           w_smask;
  logic                    w_last_in;
  logic                    w_push_hs;
  logic                    w_unused_push;

  // Input lanes are always fully valid, so the upstream strobe/last carry no information here.
  assign w_unused_push = &{push.strb, push.last};

  // Byte shift amounts; the carry is forced to zero at offset 0 to avoid a shift by the full width.
  assign w_lsh     = SW'({r_offset, 3'b000});
  assign w_rsh     = SW'(DATA_WIDTH) - w_lsh;
  assign w_shifted = push.data << w_lsh;
  assign w_carry   = (r_offset == '0) ? '0 : (push.data >> w_rsh);
  assign w_smask   = {NB{1'b1}} << r_offset;
  assign w_last_in = (r_count == (r_length - LENGTH_WIDTH'(1)));
  assign w_push_hs = (r_state == ST_STREAM) && push.valid && pop.ready;

  assign cfg_ready_o = r_cfg_ready;
  assign busy_o      = r_busy;
  assign line_done_o = r_line_done;

  // Line sequencing: config latch, beat counting, residue carry and the registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_offset    <= '0;
      r_length    <= '0;
      r_count     <= '0;
      r_residue   <= '0;
      r_cfg_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_line_done <= 1'b0;
    end else if (clear_i) begin
      r_state     <= ST_IDLE;
      r_offset    <= '0;
      r_length    <= '0;
      r_count     <= '0;
      r_residue   <= '0;
      r_cfg_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_line_done <= 1'b0;
    end else begin
      r_line_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_valid_i) begin
            if (cfg_length_i != '0) begin
              r_offset    <= cfg_offset_i;
              r_length    <= cfg_length_i;
              r_count     <= '0;
              r_residue   <= '0;
              r_state     <= ST_STREAM;
              r_cfg_ready <= 1'b0;
              r_busy      <= 1'b1;
            end else begin
              // Empty line: nothing to emit, just report completion.
              r_line_done <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (w_push_hs) begin
            r_residue <= w_carry;
            r_count   <= r_count + LENGTH_WIDTH'(1);
            if (w_last_in) begin
              if (r_offset == '0) begin
                r_state     <= ST_IDLE;
                r_cfg_ready <= 1'b1;
                r_busy      <= 1'b0;
                r_line_done <= 1'b1;
              end else begin
                r_state <= ST_FLUSH;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (pop.ready) begin
            r_state     <= ST_IDLE;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_line_done <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cfg_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency datapath: pass-through handshake while streaming, residue-only beat while flushing.
  always_comb begin
    pop.valid  = 1'b0;
    pop.data   = '0;
    pop.strb   = '0;
    pop.last   = 1'b0;
    push.ready = 1'b0;
    case (r_state)
      ST_STREAM: begin
        pop.valid  = push.valid;
        push.ready = pop.ready;
        pop.data   = w_shifted | r_residue;
        pop.strb   = (r_count == '0) ? w_smask : {NB{1'b1}};
        pop.last   = (r_offset == '0) && w_last_in;
      end
      ST_FLUSH: begin
        pop.valid = 1'b1;
        pop.data  = r_residue;
        pop.strb  = ~w_smask;
        pop.last  = 1'b1;
      end
      default: begin
        pop.valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_hwpe_stream_sink_misalign.sv
// tb/tb_hwpe_stream_sink_misalign.sv - self-checking bench for the misaligning stream sink
module tb_hwpe_stream_sink_misalign;

  localparam int DW = 32;
  localparam int NB = DW / 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_offset = '0;
  logic [15:0] cfg_length = '0;
  logic        busy;
  logic        line_done;

  hwpe_stream_sink_misalign_if #(.DATA_WIDTH(DW)) push_if ();
  hwpe_stream_sink_misalign_if #(.DATA_WIDTH(DW)) pop_if ();

  hwpe_stream_sink_misalign #(.DATA_WIDTH(DW), .LENGTH_WIDTH(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (clear),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_offset_i (cfg_offset),
    .cfg_length_i (cfg_length),
    .push         (push_if.slave),
    .pop          (pop_if.master),
    .busy_o       (busy),
    .line_done_o  (line_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] din [0:15];
  logic [DW-1:0] got_data [$];
  logic [NB-1:0] got_strb [$];
  logic          got_last [$];
  logic [DW-1:0] exp_data [$];
  logic [NB-1:0] exp_strb [$];
  logic          exp_last [$];

  int busy_cyc;
  int ld_total;
  bit ld_first;
  bit ready_ok;
  bit tail_ok;
  bit timed_out;

  // Reference: place input byte j at output byte address o+j, then cut into NB-byte beats.
  task automatic build_expected(input int o, input int len);
    int nbytes;
    int nbeats;
    int pos;
    logic [DW-1:0] d;
    logic [NB-1:0] s;
    logic [DW-1:0] w;
    exp_data.delete(); exp_strb.delete(); exp_last.delete();
    nbytes = NB * len;
    nbeats = (o + nbytes + NB - 1) / NB;
    for (int b = 0; b < nbeats; b++) begin
      d = '0;
      s = '0;
      for (int i = 0; i < NB; i++) begin
        pos = b * NB + i - o;
        if (pos >= 0 && pos < nbytes) begin
          w = din[pos / NB];
          s[i] = 1'b1;
          d[8*i +: 8] = w[8*(pos % NB) +: 8];
        end
      end
      exp_data.push_back(d);
      exp_strb.push_back(s);
      exp_last.push_back(b == nbeats - 1);
    end
  endtask

  function automatic int first_mismatch();
    if (got_data.size() != exp_data.size()) return -2;
    foreach (exp_data[i])
      if (got_data[i] !== exp_data[i] || got_strb[i] !== exp_strb[i] || got_last[i] !== exp_last[i])
        return i;
    return -1;
  endfunction

  task automatic set_exp(input logic [DW-1:0] d, input logic [NB-1:0] s, input logic l);
    exp_data.push_back(d);
    exp_strb.push_back(s);
    exp_last.push_back(l);
  endtask

  // Drives one configured line through the DUT and records every output beat and status event.
  task automatic run_line(input int o, input int len, input bit rnd);
    int cyc;
    int pushed;
    int nexp;
    bit phs;
    got_data.delete(); got_strb.delete(); got_last.delete();
    busy_cyc = 0; ld_total = 0; ld_first = 1'b0; ready_ok = 1'b1; tail_ok = 1'b1; timed_out = 1'b0;
    nexp = (o == 0) ? len : len + 1;
    @(negedge clk);
    cfg_valid  = 1'b1;
    cfg_offset = 2'(o);
    cfg_length = 16'(len);
    cyc = 0;
    #1;
    while (!cfg_ready && cyc < 100) begin
      @(negedge clk); #1; cyc++;
    end
    if (!cfg_ready) timed_out = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    pushed = 0; phs = 1'b0; cyc = 0;
    while (got_data.size() < nexp && cyc < 1000) begin
      if (phs) begin
        pushed++;
        push_if.valid = 1'b0;
      end
      if (!push_if.valid && pushed < len) begin
        push_if.data  = din[pushed];
        push_if.valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      pop_if.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (busy) busy_cyc++;
      if (line_done) ld_total++;
      if (pushed < len && busy && push_if.ready !== pop_if.ready) ready_ok = 1'b0;
      if (pop_if.valid && pop_if.ready) begin
        got_data.push_back(pop_if.data);
        got_strb.push_back(pop_if.strb);
        got_last.push_back(pop_if.last);
      end
      phs = push_if.valid && push_if.ready;
      cyc++;
      @(negedge clk);
    end
    if (got_data.size() < nexp) timed_out = 1'b1;
    push_if.valid = 1'b0;
    pop_if.ready  = 1'b0;
    #1;
    ld_first = line_done;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(negedge clk); #1;
      end
      if (line_done) ld_total++;
      if (busy) busy_cyc++;
      if (pop_if.valid) tail_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_checks++;
    if ({cfg_ready, push_if.ready, pop_if.valid, pop_if.strb, pop_if.last, busy, line_done} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_outputs: got cfg_ready=%b push_ready=%b pop_valid=%b strb=%h last=%b busy=%b done=%b, required 1 0 0 0 0 0 0",
               cfg_ready, push_if.ready, pop_if.valid, pop_if.strb, pop_if.last, busy, line_done);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: got cfg_ready=%b busy=%b, required 1 0", cfg_ready, busy);
    end
  endtask

  task automatic test_aligned();
    int idx;
    din[0] = 32'h11111111; din[1] = 32'h22222222; din[2] = 32'h33333333;
    run_line(0, 3, 1'b0);
    exp_data.delete(); exp_strb.delete(); exp_last.delete();
    set_exp(32'h11111111, 4'hF, 1'b0);
    set_exp(32'h22222222, 4'hF, 1'b0);
    set_exp(32'h33333333, 4'hF, 1'b1);
    idx = first_mismatch();
    n_checks++;
    if (idx != -1) begin
      n_errors++;
      if (idx < 0) $display("FAIL aligned_beats: got %0d beats, required %0d", got_data.size(), exp_data.size());
      else $display("FAIL aligned_beats: beat %0d got %h/%h/%b required %h/%h/%b", idx, got_data[idx], got_strb[idx], got_last[idx], exp_data[idx], exp_strb[idx], exp_last[idx]);
    end
    n_checks++;
    if (ld_first !== 1'b1 || ld_total != 1) begin
      n_errors++;
      $display("FAIL aligned_line_done: got next=%b count=%0d, required next=1 count=1", ld_first, ld_total);
    end
  endtask

  task automatic test_offset1();
    int idx;
    din[0] = 32'h44332211; din[1] = 32'h88776655;
    run_line(1, 2, 1'b0);
    exp_data.delete(); exp_strb.delete(); exp_last.delete();
    set_exp(32'h33221100, 4'hE, 1'b0);
    set_exp(32'h77665544, 4'hF, 1'b0);
    set_exp(32'h00000088, 4'h1, 1'b1);
    idx = first_mismatch();
    n_checks++;
    if (idx != -1) begin
      n_errors++;
      if (idx < 0) $display("FAIL off1_beats: got %0d beats, required %0d", got_data.size(), exp_data.size());
      else $display("FAIL off1_beats: beat %0d got %h/%h/%b required %h/%h/%b", idx, got_data[idx], got_strb[idx], got_last[idx], exp_data[idx], exp_strb[idx], exp_last[idx]);
    end
    n_checks++;
    if (ld_first !== 1'b1 || ld_total != 1) begin
      n_errors++;
      $display("FAIL off1_line_done: got next=%b count=%0d, required next=1 count=1", ld_first, ld_total);
    end
  endtask

  task automatic test_offset3_busy();
    int idx;
    din[0] = 32'hDDCCBBAA;
    run_line(3, 1, 1'b0);
    exp_data.delete(); exp_strb.delete(); exp_last.delete();
    set_exp(32'hAA000000, 4'h8, 1'b0);
    set_exp(32'h00DDCCBB, 4'h7, 1'b1);
    idx = first_mismatch();
    n_checks++;
    if (idx != -1) begin
      n_errors++;
      if (idx < 0) $display("FAIL off3_beats: got %0d beats, required %0d", got_data.size(), exp_data.size());
      else $display("FAIL off3_beats: beat %0d got %h/%h/%b required %h/%h/%b", idx, got_data[idx], got_strb[idx], got_last[idx], exp_data[idx], exp_strb[idx], exp_last[idx]);
    end
    n_checks++;
    if (busy_cyc != 2) begin
      n_errors++;
      $display("FAIL off3_busy_cycles: got %0d, required 2", busy_cyc);
    end
  endtask

  task automatic test_random();
    int o;
    int len;
    int idx;
    for (int n = 0; n < 100; n++) begin
      o   = int'($urandom_range(0, 3));
      len = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) din[i] = $urandom;
      build_expected(o, len);
      run_line(o, len, 1'b1);
      idx = first_mismatch();
      n_checks++;
      if (idx != -1) begin
        n_errors++;
        if (idx < 0) $display("FAIL rand_beats line %0d (o=%0d L=%0d): got %0d beats, required %0d", n, o, len, got_data.size(), exp_data.size());
        else $display("FAIL rand_beats line %0d (o=%0d L=%0d): beat %0d got %h/%h/%b required %h/%h/%b", n, o, len, idx, got_data[idx], got_strb[idx], got_last[idx], exp_data[idx], exp_strb[idx], exp_last[idx]);
      end
      n_checks++;
      if (!ready_ok) begin
        n_errors++;
        $display("FAIL rand_push_ready line %0d: got push_ready differing from pop_ready while streaming, required equal", n);
      end
      n_checks++;
      if (ld_first !== 1'b1 || ld_total != 1 || timed_out || !tail_ok) begin
        n_errors++;
        $display("FAIL rand_completion line %0d: got done_next=%b done_count=%0d timeout=%b tail_ok=%b, required 1 1 0 1", n, ld_first, ld_total, timed_out, tail_ok);
      end
    end
  endtask

  task automatic test_zero_length();
    int ld_cnt;
    bit saw_valid;
    bit rdy_ok;
    ld_cnt = 0; saw_valid = 1'b0; rdy_ok = 1'b1;
    @(negedge clk);
    cfg_valid  = 1'b1;
    cfg_offset = 2'd2;
    cfg_length = 16'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (line_done) ld_cnt++;
      if (pop_if.valid) saw_valid = 1'b1;
      if (!cfg_ready) rdy_ok = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (ld_cnt != 1) begin
      n_errors++;
      $display("FAIL zero_len_done: got %0d pulses, required 1", ld_cnt);
    end
    n_checks++;
    if (saw_valid || !rdy_ok) begin
      n_errors++;
      $display("FAIL zero_len_idle: got pop_valid_seen=%b cfg_ready_steady=%b, required 0 1", saw_valid, rdy_ok);
    end
  endtask

  task automatic test_clear_flush();
    int ld_cnt;
    @(negedge clk);
    cfg_valid  = 1'b1;
    cfg_offset = 2'd2;
    cfg_length = 16'd1;
    @(negedge clk);
    cfg_valid     = 1'b0;
    push_if.data  = 32'hA1B2C3D4;
    push_if.valid = 1'b1;
    pop_if.ready  = 1'b1;
    #1;
    n_checks++;
    if (pop_if.valid !== 1'b1 || pop_if.data !== 32'hC3D40000 || pop_if.strb !== 4'hC) begin
      n_errors++;
      $display("FAIL clear_first_beat: got %b/%h/%h, required 1/c3d40000/c", pop_if.valid, pop_if.data, pop_if.strb);
    end
    @(negedge clk);
    push_if.valid = 1'b0;
    pop_if.ready  = 1'b0;
    #1;
    n_checks++;
    if (pop_if.valid !== 1'b1 || pop_if.data !== 32'h0000A1B2 || pop_if.strb !== 4'h3 || pop_if.last !== 1'b1) begin
      n_errors++;
      $display("FAIL clear_flush_beat: got %b/%h/%h/%b, required 1/0000a1b2/3/1", pop_if.valid, pop_if.data, pop_if.strb, pop_if.last);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    ld_cnt = 0;
    #1;
    n_checks++;
    if (pop_if.valid !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_abort: got pop_valid=%b busy=%b, required 0 0", pop_if.valid, busy);
    end
    for (int k = 0; k < 3; k++) begin
      if (line_done) ld_cnt++;
      @(negedge clk); #1;
    end
    n_checks++;
    if (ld_cnt != 0) begin
      n_errors++;
      $display("FAIL clear_no_done: got %0d pulses, required 0", ld_cnt);
    end
    // Config and clear in the same cycle: the config must be ignored.
    @(negedge clk);
    cfg_valid  = 1'b1;
    cfg_offset = 2'd1;
    cfg_length = 16'd2;
    clear      = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    clear     = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL clear_beats_cfg: got busy=%b cfg_ready=%b, required 0 1", busy, cfg_ready);
    end
    din[0] = 32'hCAFEF00D;
    run_line(0, 1, 1'b0);
    n_checks++;
    if (got_data.size() != 1 || got_data[0] !== 32'hCAFEF00D || got_strb[0] !== 4'hF || got_last[0] !== 1'b1) begin
      n_errors++;
      if (got_data.size() != 1) $display("FAIL clear_next_line: got %0d beats, required 1", got_data.size());
      else $display("FAIL clear_next_line: got %h/%h/%b, required cafef00d/f/1", got_data[0], got_strb[0], got_last[0]);
    end
  endtask

  initial begin
    push_if.valid = 1'b0;
    push_if.data  = '0;
    push_if.strb  = '1;
    push_if.last  = 1'b0;
    pop_if.ready  = 1'b0;
    test_reset();
    test_aligned();
    test_offset1();
    test_offset3_busy();
    test_zero_length();
    test_random();
    test_clear_flush();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/hwpe_stream_sink_misalign.md
# hwpe_stream_sink_misalign

Store-side counterpart of the source realigner. Takes a fully strobed, word-aligned HWPE stream line and emits it shifted by a per-line byte offset, with byte strobes, so a downstream TCDM sink can write it to an unaligned address. Adds one flush beat per line when the offset is non-zero. Sits between the accelerator datapath output and the memory-side sink streamer.

## Interface
- DATA_WIDTH, 32, stream data width in bits (multiple of 8); NB = DATA_WIDTH/8 byte lanes
- LENGTH_WIDTH, 16, width of the line-length field (beats)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- clear_i  in  1  synchronous clear, same effect as reset
- cfg_valid_i / cfg_ready_o  in/out  1  per-line config handshake
- cfg_offset_i  in  log2(NB)  byte offset o of line start
- cfg_length_i  in  LENGTH_WIDTH  aligned input beats per line L
- push_valid_i / push_ready_o  in/out  1  aligned input stream handshake
- push_data_i  in  DATA_WIDTH  aligned input data (all bytes valid)
- pop_valid_o / pop_ready_i  out/in  1  misaligned output stream handshake
- pop_data_o  out  DATA_WIDTH  output data
- pop_strb_o  out  NB  output byte strobes
- pop_last_o  out  1  high on final output beat of a line
- busy_o  out  1  state != IDLE
- line_done_o  out  1  one-cycle pulse after line completes

## Operation
- Byte lane i = data[8i+7:8i], little-endian. Masks: S = ('1 << o) truncated to NB bits.
- Input d0..d(L-1). o==0: L output beats, out_k = d_k, strb all ones.
- o>0: L+1 beats: out_0 = d0 << 8o, strb S; out_k (1..L-1) = (d_k << 8o) | (d_(k-1) >> 8(NB-o)), strb all ones; out_L = d_(L-1) >> 8(NB-o), strb ~S.
- Residue register holds d_(k-1) >> 8(NB-o); forced to 0 when o==0 (no shift-by-width).
- FSM states IDLE, STREAM, FLUSH.
- IDLE: cfg_ready_o=1, push_ready_o=0, pop_valid_o=0. cfg handshake with L>0: latch o, L, clear beat counter and residue, go STREAM. L==0: accept, stay IDLE, pulse line_done_o.
- STREAM: pop_valid_o = push_valid_i, push_ready_o = pop_ready_i, cfg_ready_o=0. pop_data_o = (push_data_i << 8o) | residue (residue 0 on first beat). pop_strb_o = S on first beat, else all ones. On each handshake: residue updated, counter++. On handshake of beat L-1: o==0 -> pop_last_o high on that beat, go IDLE; o>0 -> go FLUSH.
- FLUSH: pop_valid_o=1, push_ready_o=0, pop_data_o = residue, pop_strb_o = ~S, pop_last_o=1. On pop_ready_i go IDLE.
- line_done_o: registered, asserted the cycle after the final output handshake (or after an L==0 config handshake).
- Counter compares against L-1 in LENGTH_WIDTH bits; L up to 2^LENGTH_WIDTH-1.

## Timing
- Reset/clear values: state IDLE, counter 0, residue 0, latched o/L 0; outputs cfg_ready_o=1, push_ready_o=0, pop_valid_o=0, pop_strb_o=0, pop_last_o=0, busy_o=0, line_done_o=0.
- STREAM datapath is combinational push->pop (zero latency); FLUSH adds exactly one beat.
- pop_valid_o never depends on pop_ready_i; pop_data/strb/last stable while pop_valid_o && !pop_ready_i given upstream holds push stable.
- Next config accepted earliest the cycle after returning to IDLE; no back-to-back overlap of lines.
- Config presented while busy is held off (cfg_ready_o=0), never dropped.
- clear_i or rst_i mid-line: in-flight line discarded, no line_done_o pulse, pop_valid_o low from next cycle (rst_i: immediately).
- Simultaneous cfg_valid_i and clear_i: clear wins, config not accepted.

## Test plan
- DATA_WIDTH=32, o=0, L=3, d=0x11111111,0x22222222,0x33333333 -> identical 3 beats, strb 0xF, pop_last_o on beat 3, line_done_o pulse next cycle.
- o=1, L=2, d=0x44332211,0x88776655 -> 0x33221100/0xE, 0x77665544/0xF, 0x00000088/0x1 with pop_last_o.
- o=3, L=1, d=0xDDCCBBAA -> 0xAA000000/0x8, 0x00DDCCBB/0x7 last; busy_o high exactly 2 cycles with ready tied high.
- Random 50% pop_ready_i and push_valid_i gaps, 100 lines random o, L in 1..8 -> output equals reference byte-shift model, no dropped/duplicated beats, push_ready_o == pop_ready_i in STREAM.
- L=0 config -> no pop_valid_o, line_done_o one pulse, cfg_ready_o stays 1.
- clear_i asserted during FLUSH of o=2 line -> pop_valid_o low next cycle, busy_o 0, no line_done_o; following o=0, L=1 line passes unchanged.
